// File: rtl/soma_operand_loader.sv
// soma_operand_loader: sequential front/back end for the combinational signed
// adder. Loads operand A then operand B from one shared bus on successive
// load strobes, drives them to the adder, and captures S/Z/N/P one cycle later.
//
// Optional feature: define SOMA_OVF_EN to add a registered signed-overflow flag;
// without it, ovf is tied low and no overflow register exists.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   din                 operand data, sampled on an accepted load strobe
//   load                load request level (rising edge accepted)
//   clear               synchronous clear, dominates load
//   a, b                registered operands to the adder (signed)
//   s_in, z_in, n_in, p_in  adder sum and flags
//   result, z, n, p     registered captured sum and flags
//   state               current FSM state encoding
//   done                result/flags valid for the current A,B pair
//   ovf                 signed overflow (SOMA_OVF_EN only, else 0)
module soma_operand_loader #(
  parameter int unsigned NBITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic        [NBITS-1:0] din,
  input  logic                    load,
  input  logic                    clear,
  output logic signed [NBITS-1:0] a,
  output logic signed [NBITS-1:0] b,
  input  logic        [NBITS-1:0] s_in,
  input  logic                    z_in,
  input  logic                    n_in,
  input  logic                    p_in,
  output logic signed [NBITS-1:0] result,
  output logic                    z,
  output logic                    n,
  output logic                    p,
  output logic        [1:0]       state,
  output logic                    done,
  output logic                    ovf
);

  typedef enum logic [1:0] {
    ST_A    = 2'd0,
    ST_B    = 2'd1,
    ST_CAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic                    load_q, load_d;
  logic signed [NBITS-1:0] a_q, a_d;
  logic signed [NBITS-1:0] b_q, b_d;
  logic signed [NBITS-1:0] result_q, result_d;
  logic                    z_q, z_d;
  logic                    n_q, n_d;
  logic                    p_q, p_d;
  logic                    done_q, done_d;
  logic                    ld_c;

  // One strobe per rising edge of the (possibly held) load level
  assign ld_c = load & ~load_q;

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    load_d   = load;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    z_d      = z_q;
    n_d      = n_q;
    p_d      = p_q;
    done_d   = done_q;

    if (clear) begin
      state_d  = ST_A;
      a_d      = '0;
      b_d      = '0;
      result_d = '0;
      z_d      = 1'b0;
      n_d      = 1'b0;
      p_d      = 1'b0;
      done_d   = 1'b0;
    end else begin
      case (state_q)
        ST_A: begin
          if (ld_c) begin
            a_d     = din;
            state_d = ST_B;
          end
        end
        ST_B: begin
          if (ld_c) begin
            b_d     = din;
            state_d = ST_CAP;
          end
        end
        // b was written last edge, so the adder output has settled
        ST_CAP: begin
          result_d = s_in;
          z_d      = z_in;
          n_d      = n_in;
          p_d      = p_in;
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end
        // Chained entry: old result stays visible until the next capture
        ST_DONE: begin
          if (ld_c) begin
            a_d     = din;
            done_d  = 1'b0;
            state_d = ST_B;
          end
        end
        default: state_d = ST_A;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_A;
      load_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      p_q      <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      load_q   <= load_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      z_q      <= z_d;
      n_q      <= n_d;
      p_q      <= p_d;
      done_q   <= done_d;
    end
  end

`ifdef SOMA_OVF_EN
  logic ovf_q, ovf_d;

  // Overflow: like-signed operands giving a sum of the opposite sign
  always_comb begin
    ovf_d = ovf_q;
    if (clear) begin
      ovf_d = 1'b0;
    end else if (state_q == ST_CAP) begin
      ovf_d = (a_q[NBITS-1] == b_q[NBITS-1]) && (s_in[NBITS-1] != a_q[NBITS-1]);
    end else if ((state_q == ST_DONE) && ld_c) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign a      = a_q;
  assign b      = b_q;
  assign result = result_q;
  assign z      = z_q;
  assign n      = n_q;
  assign p      = p_q;
  assign state  = state_q;
  assign done   = done_q;

endmodule

// File: tb/tb_soma_operand_loader.sv
// Testbench for soma_operand_loader: directed scenarios plus randomized traffic,
// checked against a behavioural model of the load/capture rules. The adder is
// modelled here as a plain 8-bit sum with zero/negative/even flags.
module tb_soma_operand_loader;

  logic              clk;
  logic              rst_n;
  logic        [7:0] din;
  logic              load;
  logic              clear;
  logic signed [7:0] a;
  logic signed [7:0] b;
  logic        [7:0] s_in;
  logic              z_in;
  logic              n_in;
  logic              p_in;
  logic signed [7:0] result;
  logic              z;
  logic              n;
  logic              p;
  logic        [1:0] state;
  logic              done;
  logic              ovf;

  int checks;
  int errors;

  soma_operand_loader #(.NBITS(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (din),
    .load   (load),
    .clear  (clear),
    .a      (a),
    .b      (b),
    .s_in   (s_in),
    .z_in   (z_in),
    .n_in   (n_in),
    .p_in   (p_in),
    .result (result),
    .z      (z),
    .n      (n),
    .p      (p),
    .state  (state),
    .done   (done),
    .ovf    (ovf)
  );

  // External combinational adder
  assign s_in = a + b;
  assign z_in = (s_in == 8'd0);
  assign n_in = s_in[7];
  assign p_in = ~s_in[0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  localparam logic [1:0] E_A = 2'd0, E_B = 2'd1, E_CAP = 2'd2, E_DONE = 2'd3;
  logic signed [7:0] m_a, m_b, m_res;
  logic              m_z, m_n, m_p, m_done, m_ovf, m_load_q;
  logic        [1:0] m_st;

  task automatic model_reset();
    m_a = 0; m_b = 0; m_res = 0;
    m_z = 0; m_n = 0; m_p = 0; m_done = 0; m_ovf = 0; m_load_q = 0;
    m_st = E_A;
  endtask

  // Apply one rising edge of the spec rules with the inputs present at that edge
  task automatic model_step(input logic ld_lvl, input logic clr, input logic [7:0] d);
    logic strobe;
    int   sum_i;
    logic [7:0] r;
    strobe   = ld_lvl && !m_load_q;
    m_load_q = ld_lvl;
    if (clr) begin
      m_a = 0; m_b = 0; m_res = 0;
      m_z = 0; m_n = 0; m_p = 0; m_done = 0; m_ovf = 0;
      m_st = E_A;
    end else if (m_st == E_A) begin
      if (strobe) begin m_a = d; m_st = E_B; end
    end else if (m_st == E_B) begin
      if (strobe) begin m_b = d; m_st = E_CAP; end
    end else if (m_st == E_CAP) begin
      sum_i  = int'(m_a) + int'(m_b);
      r      = 8'(sum_i);
      m_res  = r;
      m_z    = (sum_i % 256 == 0);
      m_n    = (int'($signed(r)) < 0);
      m_p    = ((sum_i % 2) == 0);
`ifdef SOMA_OVF_EN
      m_ovf  = (sum_i > 127) || (sum_i < -128);
`else
      m_ovf  = 1'b0;
`endif
      m_done = 1'b1;
      m_st   = E_DONE;
    end else begin
      if (strobe) begin m_a = d; m_done = 0; m_ovf = 0; m_st = E_B; end
    end
  endtask

  function automatic logic [30:0] obs_vec();
    return {a, b, result, z, n, p, state, done, ovf};
  endfunction

  function automatic logic [30:0] exp_vec();
    return {m_a, m_b, m_res, m_z, m_n, m_p, m_st, m_done, m_ovf};
  endfunction

  // Drive one cycle's inputs (called at a falling edge), returns at the next falling edge
  task automatic cycle(input logic ld_lvl, input logic clr, input logic [7:0] d);
    load  = ld_lvl;
    clear = clr;
    din   = d;
    @(posedge clk);
    model_step(ld_lvl, clr, d);
    @(negedge clk);
  endtask

  // Load A and B as clean pulses, then the capture cycle
  task automatic run_pair(input logic [7:0] va, input logic [7:0] vb);
    cycle(1'b1, 1'b0, va);
    cycle(1'b0, 1'b0, va);
    cycle(1'b1, 1'b0, vb);
    cycle(1'b0, 1'b0, vb);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; load = 0; clear = 0; din = 0;
    model_reset();
    @(negedge clk);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset: got %h expected %h", obs_vec(), exp_vec());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed(input string name, input logic [7:0] va, input logic [7:0] vb,
                               input logic [7:0] eres, input logic [2:0] ezn_p,
                               input logic eovf_en);
    logic eovf;
`ifdef SOMA_OVF_EN
    eovf = eovf_en;
`else
    eovf = 1'b0;
`endif
    cycle(1'b0, 1'b1, 8'h00);
    run_pair(va, vb);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL %s model: got %h expected %h", name, obs_vec(), exp_vec());
    end
    checks++;
    if ({result, z, n, p, done, ovf, state} !== {eres, ezn_p, 1'b1, eovf, 2'd3}) begin
      errors++;
      $display("FAIL %s const: got res=%h znp=%b done=%b ovf=%b st=%0d expected res=%h znp=%b done=1 ovf=%b st=3",
               name, result, {z, n, p}, done, ovf, state, eres, ezn_p, eovf);
    end
  endtask

  task automatic test_held_load();
    cycle(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 8'h5A);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL held_load cyc%0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if ({state, a, b} !== {2'd1, 8'h5A, 8'h00}) begin
      errors++;
      $display("FAIL held_load final: got st=%0d a=%h b=%h expected st=1 a=5a b=00", state, a, b);
    end
    cycle(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_clear_priority();
    cycle(1'b0, 1'b1, 8'h00);
    run_pair(8'h05, 8'h03);
    cycle(1'b1, 1'b1, 8'h77);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL clear_priority model: got %h expected %h", obs_vec(), exp_vec());
    end
    checks++;
    if ({state, a, b, result, done} !== {2'd0, 8'h00, 8'h00, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL clear_priority const: got st=%0d a=%h b=%h res=%h done=%b expected all 0",
               state, a, b, result, done);
    end
    cycle(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_chained();
    cycle(1'b0, 1'b1, 8'h00);
    run_pair(8'h05, 8'h03);
    cycle(1'b1, 1'b0, 8'hF0);
    checks++;
    if ({a, done, state, result} !== {8'hF0, 1'b0, 2'd1, 8'h08}) begin
      errors++;
      $display("FAIL chained_a: got a=%h done=%b st=%0d res=%h expected a=f0 done=0 st=1 res=08",
               a, done, state, result);
    end
    cycle(1'b0, 1'b0, 8'hF0);
    cycle(1'b1, 1'b0, 8'hF0);
    cycle(1'b0, 1'b0, 8'hF0);
    checks++;
    if ({result, z, n, p, done} !== {8'hE0, 1'b0, 1'b1, 1'b1, 1'b1} || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL chained_sum: got %h expected %h (res should be e0 n=1 p=1)", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b0, 1'b1, 8'h00);
    run_pair(8'h05, 8'h03);
    cycle(1'b1, 1'b0, 8'h09);
    cycle(1'b0, 1'b0, 8'h09);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_mid: got %h expected %h", obs_vec(), exp_vec());
    end
    load = 0; clear = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic ld_lvl, clr;
    logic [7:0] d;
    cycle(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 400; i++) begin
      ld_lvl = ($urandom_range(0, 2) == 0);
      clr    = ($urandom_range(0, 40) == 0);
      d      = 8'($urandom);
      cycle(ld_lvl, clr, d);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc%0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed("add_5_3",   8'h05, 8'h03, 8'h08, 3'b001, 1'b0);
    test_directed("add_m4_4",  8'hFC, 8'h04, 8'h00, 3'b101, 1'b0);
    test_directed("ovf_7f_01", 8'h7F, 8'h01, 8'h80, 3'b011, 1'b1);
    test_directed("ovf_80_ff", 8'h80, 8'hFF, 8'h7F, 3'b000, 1'b1);
    test_held_load();
    test_clear_priority();
    test_chained();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
